// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
//
// Word-organised data memory with a fixed-latency request/response handshake.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, and is then
// presented in RESP until the core takes it. Misaligned or out-of-range
// requests complete with resp_err=1, zero data and no storage side effects.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words stored
//   LATENCY      cycles from accept to resp_valid (1..15)
//
// Ports
//   clk           clock, rising edge
//   rst_b         asynchronous active-low reset
//   mem_addr      byte address; lane k is the byte at mem_addr+k
//   mem_data_in   write bytes, lane k = mem_data_in[k]
//   mem_write_en  1 = write request, 0 = read request
//   req_valid     core presents a request
//   req_ready     request can be accepted this cycle
//   mem_data_out  response data, lane k = mem_data_out[k]
//   resp_valid    response present
//   resp_ready    core consumes the response
//   resp_err      request was misaligned or out of range
//   halted        core halted; blocks acceptance of new requests
// -----------------------------------------------------------------------------
module data_mem #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic [31:0]     mem_addr,
   input  logic [3:0][7:0] mem_data_in,
   input  logic            mem_write_en,
   input  logic            req_valid,
   output logic            req_ready,
   output logic [3:0][7:0] mem_data_out,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_err,
   input  logic            halted
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;

   // Request captured at accept; held untouched until the next IDLE.
   logic [31:0]     addr_q;
   logic            we_q;
   logic [3:0][7:0] wdata_q;

   // Response held across RESP and beyond (data must persist after RESP).
   logic [3:0][7:0] rdata_q;
   logic            err_q;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            accept;
   logic            commit;
   logic            req_err;
   logic [IDX_W-1:0] word_idx;

   assign accept   = req_valid && req_ready;
   // The WAIT->RESP edge is where storage is read or written.
   assign commit   = (state_q == WAIT) && (cnt_q == 4'd1);
   // Compare the full word address, not the truncated index, so that
   // out-of-range requests never alias onto a low word.
   assign req_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
   assign word_idx = addr_q[IDX_W+1:2];

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WAIT;
               cnt_d   = 4'(LATENCY);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      // rst_b gates req_ready so nothing is advertised while reset is held.
      req_ready    = rst_b && (state_q == IDLE) && !halted;
      resp_valid   = (state_q == RESP);
      resp_err     = (state_q == RESP) && err_q;
      mem_data_out = rdata_q;
   end

   // ---------------------------------------------------------------------
   // Request capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         addr_q  <= 32'd0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= mem_addr;
         we_q    <= mem_write_en;
         wdata_q <= mem_data_in;
      end
   end

   // ---------------------------------------------------------------------
   // Response capture: registered read of storage on the commit edge.
   // A write returns the bytes it wrote; an error returns zero.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (commit) begin
         err_q <= req_err;
         if (req_err) begin
            rdata_q <= '0;
         end else if (we_q) begin
            rdata_q <= wdata_q;
         end else begin
            rdata_q <= mem[word_idx];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Storage: no reset, so contents survive rst_b. A reset during WAIT
   // returns the FSM to IDLE before the commit edge, so no write happens.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_b && commit && we_q && !req_err) begin
         mem[word_idx] <= wdata_q;
      end
   end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response valid, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 mem_addr  input  32  byte address from core; lane k = byte at mem_addr+k, little-endian.
REQ-006 mem_data_in  input  4x8 (index 0..3)  write bytes from core.
REQ-007 mem_write_en  input  1  request is a write when 1, read when 0.
REQ-008 req_valid  input  1  core presents a request.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 mem_data_out  output  4x8 (index 0..3)  read data returned to core.
REQ-011 resp_valid  output  1  response present on mem_data_out/resp_err.
REQ-012 resp_ready  input  1  core consumes the response.
REQ-013 resp_err  output  1  request was misaligned or out of range.
REQ-014 halted  input  1  core halted; blocks new requests.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE with halted=0.
REQ-017 Accept occurs on a rising edge with req_valid=1 and req_ready=1; block SHALL latch mem_addr, mem_write_en, mem_data_in, and SHALL ignore inputs until the next IDLE.
REQ-018 On accept: IDLE->WAIT, counter loaded with LATENCY; counter decrements by 1 each cycle in WAIT; when counter reaches 1, WAIT->RESP on the next edge.
REQ-019 Accept at edge N SHALL yield resp_valid=1 after edge N+LATENCY; LATENCY=1 gives resp_valid one cycle after accept.
REQ-020 Error condition: latched addr[1:0]!=0, or addr[31:2]>=DEPTH_WORDS; error requests SHALL set resp_err=1, mem_data_out=0, and SHALL NOT modify storage.
REQ-021 Valid write SHALL commit all four lanes to word addr[31:2] on the WAIT->RESP edge; mem_data_out SHALL equal the written bytes.
REQ-022 Valid read SHALL sample word addr[31:2] on the WAIT->RESP edge into mem_data_out, lane k = byte k.
REQ-023 In RESP: resp_valid=1, mem_data_out and resp_err stable until the edge with resp_ready=1; then RESP->IDLE.
REQ-024 resp_ready=1 in the first RESP cycle SHALL give a one-cycle RESP; one-cycle IDLE always follows, so back-to-back accepts are LATENCY+2 cycles apart.
REQ-025 resp_valid, resp_err SHALL be 0 outside RESP; mem_data_out SHALL hold its last response value outside RESP.
REQ-026 halted=1 SHALL block acceptance only; a request already in WAIT or RESP SHALL complete normally.
REQ-027 Read after write to the same word SHALL return the newly written data.

Reset
REQ-028 rst_b=0 SHALL immediately force state IDLE, counter 0, resp_valid=0, resp_err=0, mem_data_out all lanes 0.
REQ-029 req_ready SHALL be 0 while rst_b=0, and 1 on the first edge after release when halted=0.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted in WAIT SHALL abandon the request with no storage write; reset in RESP SHALL drop the response.

Verification
REQ-032 Write addr 0x10 bytes {0x11,0x22,0x33,0x44}, LATENCY=2, resp_ready=1 -> resp_valid high exactly 2 cycles after accept, resp_err=0; then read 0x10 -> lanes 0..3 = 0x11,0x22,0x33,0x44.
REQ-033 Read addr 0x12 -> resp_err=1, mem_data_out=0; read 0x10 -> unchanged data.
REQ-034 Write addr DEPTH_WORDS*4 -> resp_err=1; then read addr (DEPTH_WORDS-1)*4 -> contents unchanged from its prior write.
REQ-035 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable for all 5; req_ready=0 throughout; on resp_ready=1 -> IDLE next cycle.
REQ-036 halted=1 with req_valid=1 in IDLE -> no accept, req_ready=0; halted raised during WAIT -> response still delivered.
REQ-037 rst_b pulsed low during WAIT of a write to 0x20 (prior value 0xAABBCCDD) -> outputs 0 immediately; subsequent read 0x20 returns 0xAABBCCDD.
